// File: rtl/irq_event_capture_pkg.sv
// irq_capture_pkg: shared types, constants and helpers for the IRQ event capture block.
package irq_capture_pkg;

  // Width of the presented event index (covers up to 32 sources).
  localparam int EVT_ID_W = 5;
  // Widest source vector the helpers accept.
  localparam int MAX_SRC = 32;

  // Per-source detection mode, encoded as in the cfg_edge field.
  typedef enum logic [1:0] {
    RISE  = 2'b00,
    FALL  = 2'b01,
    BOTH  = 2'b10,
    LEVEL = 2'b11
  } edge_mode_t;

  // Presenter FSM states.
  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } pres_state_t;

  // Index of the lowest set bit; zero when the vector is empty.
  function automatic logic [EVT_ID_W-1:0] lowest_set(input logic [MAX_SRC-1:0] vec);
    logic [EVT_ID_W-1:0] idx;
    idx = '0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = EVT_ID_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Event decision for one source: edges are only trusted once the input
  // pipeline holds real samples, level mode follows the filtered level directly.
  function automatic logic edge_event(input edge_mode_t mode, input logic lvl,
                                      input logic prev, input logic edges_ok);
    logic hit;
    case (mode)
      RISE:    hit = lvl & ~prev & edges_ok;
      FALL:    hit = ~lvl & prev & edges_ok;
      BOTH:    hit = (lvl ^ prev) & edges_ok;
      LEVEL:   hit = lvl;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/irq_event_capture_if.sv
// irq_event_capture_if: valid/ready event handshake between capture block and interrupt manager.
interface irq_event_capture_if;
  import irq_capture_pkg::*;

  logic                evt_valid;
  logic [EVT_ID_W-1:0] evt_id;
  logic                evt_ready;

  modport master (output evt_valid, output evt_id, input evt_ready);
  modport slave  (input evt_valid, input evt_id, output evt_ready);
endinterface

// File: rtl/irq_event_capture_debounce.sv
// irq_debounce: two-flop synchroniser for one raw source, followed by an optional
// stability filter. Optional build macro: IRQ_EVENT_CAPTURE_DEBOUNCE_EN.
module irq_debounce
`ifdef IRQ_EVENT_CAPTURE_DEBOUNCE_EN
#(
  parameter int DEBOUNCE_CYCLES = 16
)
`endif
(
  input  logic aclk,
  input  logic areset,
  input  logic raw_i,
  output logic filt_o
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  // Next values of the synchroniser chain.
  always_comb begin
    sync1_d = raw_i;
    sync2_d = sync1_q;
  end

  // Synchroniser flops.
  always_ff @(posedge aclk) begin
    if (areset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef IRQ_EVENT_CAPTURE_DEBOUNCE_EN
  // Counter runs 0..DEBOUNCE_CYCLES-1 over consecutive differing samples.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             filt_q, filt_d;

  // Flip the filtered level on the DEBOUNCE_CYCLES-th differing sample in a row.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync2_q;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Filter state.
  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt_o = filt_q;
`else
  assign filt_o = sync2_q;
`endif

endmodule

// File: rtl/irq_event_capture.sv
// irq_event_capture: synchronises (optionally debounces) raw event sources, detects
// edges/levels, latches pending events with sticky overflow, and presents them one at
// a time over a valid/ready handshake. Optional build macro: IRQ_EVENT_CAPTURE_DEBOUNCE_EN.
module irq_event_capture
  import irq_capture_pkg::*;
#(
  parameter int NUM_SRC         = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [NUM_SRC-1:0]   src_raw,
  input  logic [NUM_SRC-1:0]   cfg_enable,
  input  logic [2*NUM_SRC-1:0] cfg_edge,
  irq_event_capture_if.master  evt,
  output logic [NUM_SRC-1:0]   pending,
  output logic [NUM_SRC-1:0]   overflow,
  input  logic [NUM_SRC-1:0]   ovf_clr
);

  // After reset the sync/filter chain restarts from 0, so a source that is already
  // high would look like a rising edge. Edge detection stays blind until the chain
  // (and filter, if present) has had time to reflect the real input.
`ifdef IRQ_EVENT_CAPTURE_DEBOUNCE_EN
  localparam int WARM_LAST = DEBOUNCE_CYCLES + 3;
`else
  localparam int WARM_LAST = 3;
`endif
  localparam int WARM_W = $clog2(DEBOUNCE_CYCLES + 4);

  logic [NUM_SRC-1:0]  filt_s;
  logic [NUM_SRC-1:0]  dly_q, dly_d;
  logic [NUM_SRC-1:0]  evt_raw_s, evt_lvl_s;
  logic [NUM_SRC-1:0]  evt_q, evt_d;
  logic [NUM_SRC-1:0]  evt_lvl_q, evt_lvl_d;
  logic [NUM_SRC-1:0]  pending_q, pending_d;
  logic [NUM_SRC-1:0]  overflow_q, overflow_d;
  logic [NUM_SRC-1:0]  accept_s;
  logic [NUM_SRC-1:0]  pend_en_s;
  logic [WARM_W-1:0]   warm_q, warm_d;
  logic                warm_done_s;
  logic                accept_fire_s;
  pres_state_t         state_q, state_d;
  logic                evt_valid_q, evt_valid_d;
  logic [EVT_ID_W-1:0] evt_id_q, evt_id_d;

  // Per-source synchroniser and optional filter.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    irq_debounce
`ifdef IRQ_EVENT_CAPTURE_DEBOUNCE_EN
      #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
      u_deb (
        .aclk   (aclk),
        .areset (areset),
        .raw_i  (src_raw[g]),
        .filt_o (filt_s[g])
      );
  end

  assign warm_done_s   = (warm_q == WARM_W'(WARM_LAST));
  assign accept_fire_s = (state_q == PRESENT) & evt_valid_q & evt.evt_ready;
  assign pend_en_s     = pending_q & cfg_enable;

  // Warm-up counter saturates once the input pipeline is trustworthy.
  always_comb begin
    if (warm_done_s) begin
      warm_d = warm_q;
    end else begin
      warm_d = warm_q + WARM_W'(1);
    end
  end

  // Edge/level detection against the delayed filtered level.
  always_comb begin
    evt_raw_s = '0;
    evt_lvl_s = '0;
    dly_d     = filt_s;
    for (int i = 0; i < NUM_SRC; i++) begin
      evt_lvl_s[i] = (edge_mode_t'(cfg_edge[2*i +: 2]) == LEVEL);
      evt_raw_s[i] = edge_event(edge_mode_t'(cfg_edge[2*i +: 2]), filt_s[i], dly_q[i],
                                warm_done_s);
    end
    evt_d     = evt_raw_s;
    evt_lvl_d = evt_lvl_s;
  end

  // Pending/overflow update: a new event beats acceptance, overflow set beats clear.
  always_comb begin
    accept_s   = '0;
    pending_d  = pending_q;
    overflow_d = overflow_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      accept_s[i] = accept_fire_s & (evt_id_q == EVT_ID_W'(i));
      if (evt_q[i] & cfg_enable[i]) begin
        pending_d[i] = 1'b1;
      end else if (accept_s[i]) begin
        pending_d[i] = 1'b0;
      end else begin
        pending_d[i] = pending_q[i];
      end
      if (evt_q[i] & cfg_enable[i] & ~evt_lvl_q[i] & pending_q[i] & ~accept_s[i]) begin
        overflow_d[i] = 1'b1;
      end else if (ovf_clr[i]) begin
        overflow_d[i] = 1'b0;
      end else begin
        overflow_d[i] = overflow_q[i];
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      warm_q     <= '0;
      dly_q      <= '0;
      evt_q      <= '0;
      evt_lvl_q  <= '0;
      pending_q  <= '0;
      overflow_q <= '0;
    end else begin
      warm_q     <= warm_d;
      dly_q      <= dly_d;
      evt_q      <= evt_d;
      evt_lvl_q  <= evt_lvl_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  // Presenter state register with its registered outputs.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= IDLE;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      evt_valid_q <= evt_valid_d;
      evt_id_q    <= evt_id_d;
    end
  end

  // Presenter next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (|pend_en_s) begin
          state_d = PRESENT;
        end else begin
          state_d = IDLE;
        end
      end
      PRESENT: begin
        if (accept_fire_s) begin
          state_d = IDLE;
        end else begin
          state_d = PRESENT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Presenter outputs: pick lowest enabled pending source, hold it until accepted.
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    case (state_q)
      IDLE: begin
        if (|pend_en_s) begin
          evt_valid_d = 1'b1;
          evt_id_d    = lowest_set(MAX_SRC'(pend_en_s));
        end else begin
          evt_valid_d = 1'b0;
        end
      end
      PRESENT: begin
        if (accept_fire_s) begin
          evt_valid_d = 1'b0;
        end else begin
          evt_valid_d = 1'b1;
        end
      end
      default: begin
        evt_valid_d = 1'b0;
        evt_id_d    = '0;
      end
    endcase
  end

  assign evt.evt_valid = evt_valid_q;
  assign evt.evt_id    = evt_id_q;
  assign pending       = pending_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_irq_event_capture.sv
// tb_irq_event_capture: table-driven vectors over modes/enables plus directed sequences
// for latency, arbitration, overflow, hold, reset and debounce behaviour.
module tb_irq_event_capture;

  localparam int NSRC = 8;
  localparam int DEB  = 16;
`ifdef IRQ_EVENT_CAPTURE_DEBOUNCE_EN
  localparam int LAT = DEB;
`else
  localparam int LAT = 0;
`endif

  logic            aclk;
  logic            areset;
  logic [NSRC-1:0] src_raw;
  logic [NSRC-1:0] cfg_enable;
  logic [2*NSRC-1:0] cfg_edge;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] overflow;
  logic [NSRC-1:0] ovf_clr;

  int n_cmp;
  int n_bad;

  irq_event_capture_if evt_if ();

  irq_event_capture #(.NUM_SRC(NSRC), .DEBOUNCE_CYCLES(DEB)) dut (
    .aclk       (aclk),
    .areset     (areset),
    .src_raw    (src_raw),
    .cfg_enable (cfg_enable),
    .cfg_edge   (cfg_edge),
    .evt        (evt_if.master),
    .pending    (pending),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    int         src;
    logic [1:0] mode;
    logic       en;
    logic       lvl0;
    logic       lvl1;
    logic       exp;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bit_of(input logic [NSRC-1:0] v, input int i);
    return 32'((v >> i) & 8'd1);
  endfunction

  task automatic tick();
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic set_src(input int s, input logic v);
    if (v) src_raw = src_raw | 8'(1 << s);
    else   src_raw = src_raw & ~8'(1 << s);
  endtask

  task automatic set_cfg(input int s, input logic [1:0] m, input logic en);
    cfg_edge[2*s +: 2] = m;
    if (en) cfg_enable = cfg_enable | 8'(1 << s);
    else    cfg_enable = cfg_enable & ~8'(1 << s);
  endtask

  task automatic reset_all();
    src_raw          = '0;
    cfg_enable       = '0;
    cfg_edge         = '0;
    ovf_clr          = '0;
    evt_if.evt_ready = 1'b0;
    areset           = 1'b1;
    tick();
    areset = 1'b0;
  endtask

  initial begin
    int pend_e;
    int val_e;
    int n_pres;
    int ids [4];
    int cyc [4];
    int quiet_bad;

    n_cmp = 0;
    n_bad = 0;

    // {src, mode, enable, start level, end level, expect event}
    vecs[0] = '{3, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{3, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{6, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{6, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{0, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{7, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{2, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{5, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0};

    areset = 1'b1;
    src_raw = '0; cfg_enable = '0; cfg_edge = '0; ovf_clr = '0;
    evt_if.evt_ready = 1'b0;
    tick();
    tick();
    chk("rst_pending",   32'(pending), 32'h0);
    chk("rst_overflow",  32'(overflow), 32'h0);
    chk("rst_evt_valid", 32'(evt_if.evt_valid), 32'h0);
    chk("rst_evt_id",    32'(evt_if.evt_id), 32'h0);

    // Table-driven mode/enable vectors.
    for (int v = 0; v < 9; v++) begin
      reset_all();
      set_src(vecs[v].src, vecs[v].lvl0);
      set_cfg(vecs[v].src, vecs[v].mode, vecs[v].en);
      repeat (30) tick();
      chk($sformatf("vec%0d_pre_pending", v), 32'(pending), 32'h0);
      set_src(vecs[v].src, vecs[v].lvl1);
      repeat (5 + LAT) tick();
      chk($sformatf("vec%0d_pending", v), bit_of(pending, vecs[v].src), 32'(vecs[v].exp));
      chk($sformatf("vec%0d_overflow", v), 32'(overflow), 32'h0);
      chk($sformatf("vec%0d_valid", v), 32'(evt_if.evt_valid), 32'(vecs[v].exp));
      if (vecs[v].exp) chk($sformatf("vec%0d_id", v), 32'(evt_if.evt_id), 32'(vecs[v].src));
    end

    // Latency of a single rising event on source 3, then acceptance.
    reset_all();
    set_cfg(3, 2'b00, 1'b1);
    repeat (30) tick();
    pend_e = -1;
    val_e  = -1;
    set_src(3, 1'b1);
    for (int e = 0; e < 30; e++) begin
      tick();
      if (pend_e < 0 && pending[3]) pend_e = e;
      if (val_e < 0 && evt_if.evt_valid) val_e = e;
    end
    chk("lat_pending_edge", 32'(pend_e), 32'(3 + LAT));
    chk("lat_valid_edge",   32'(val_e),  32'(4 + LAT));
    chk("lat_evt_id",       32'(evt_if.evt_id), 32'd3);
    evt_if.evt_ready = 1'b1;
    tick();
    evt_if.evt_ready = 1'b0;
    chk("lat_pending_cleared", bit_of(pending, 3), 32'h0);
    chk("lat_valid_dropped",   32'(evt_if.evt_valid), 32'h0);

    // Two simultaneous sources with ready held high: lowest first, next two cycles later.
    reset_all();
    set_cfg(1, 2'b00, 1'b1);
    set_cfg(5, 2'b00, 1'b1);
    repeat (30) tick();
    evt_if.evt_ready = 1'b1;
    n_pres = 0;
    set_src(1, 1'b1);
    set_src(5, 1'b1);
    for (int c = 0; c < 40; c++) begin
      tick();
      if (evt_if.evt_valid && n_pres < 4) begin
        ids[n_pres] = int'(evt_if.evt_id);
        cyc[n_pres] = c;
        n_pres++;
      end
    end
    evt_if.evt_ready = 1'b0;
    chk("arb_count", 32'(n_pres), 32'd2);
    if (n_pres == 2) begin
      chk("arb_first_id",  32'(ids[0]), 32'd1);
      chk("arb_second_id", 32'(ids[1]), 32'd5);
      chk("arb_spacing",   32'(cyc[1] - cyc[0]), 32'd2);
    end

    // Source 2 fires twice unaccepted: overflow, then write-1-to-clear.
    reset_all();
    set_cfg(2, 2'b00, 1'b1);
    repeat (30) tick();
    set_src(2, 1'b1); repeat (25) tick();
    set_src(2, 1'b0); repeat (25) tick();
    set_src(2, 1'b1); repeat (25) tick();
    chk("ovf_set",       bit_of(overflow, 2), 32'h1);
    chk("ovf_pending",   bit_of(pending, 2), 32'h1);
    chk("ovf_valid",     32'(evt_if.evt_valid), 32'h1);
    chk("ovf_id",        32'(evt_if.evt_id), 32'd2);
    ovf_clr = 8'h04;
    tick();
    ovf_clr = 8'h00;
    chk("ovf_cleared",       bit_of(overflow, 2), 32'h0);
    chk("ovf_pending_after", bit_of(pending, 2), 32'h1);

    // Long stall with the presented source disabled: output must hold.
    cfg_enable = '0;
    for (int c = 0; c < 50; c++) begin
      tick();
      chk($sformatf("hold_valid_c%0d", c), 32'(evt_if.evt_valid), 32'h1);
      chk($sformatf("hold_id_c%0d", c),    32'(evt_if.evt_id), 32'd2);
    end

    // Reset while presenting source 4, input left high afterwards.
    reset_all();
    set_cfg(4, 2'b00, 1'b1);
    repeat (30) tick();
    set_src(4, 1'b1);
    repeat (10 + LAT) tick();
    chk("rstp_valid_before", 32'(evt_if.evt_valid), 32'h1);
    chk("rstp_id_before",    32'(evt_if.evt_id), 32'd4);
    areset = 1'b1;
    tick();
    chk("rstp_valid_after",   32'(evt_if.evt_valid), 32'h0);
    chk("rstp_pending_after", 32'(pending), 32'h0);
    areset = 1'b0;
    quiet_bad = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (evt_if.evt_valid || (pending != '0)) quiet_bad++;
    end
    chk("rstp_quiet_cycles", 32'(quiet_bad), 32'h0);

    // Short glitches versus a longer pulse on source 0, ready high, count presentations.
    reset_all();
    set_cfg(0, 2'b00, 1'b1);
    repeat (30) tick();
    evt_if.evt_ready = 1'b1;
`ifdef IRQ_EVENT_CAPTURE_DEBOUNCE_EN
    n_pres = 0;
    set_src(0, 1'b1);
    for (int c = 0; c < 10; c++) begin tick(); if (evt_if.evt_valid) n_pres++; end
    set_src(0, 1'b0);
    for (int c = 0; c < 40; c++) begin tick(); if (evt_if.evt_valid) n_pres++; end
    chk("deb_glitch_events", 32'(n_pres), 32'd0);
    n_pres = 0;
    set_src(0, 1'b1);
    for (int c = 0; c < 20; c++) begin tick(); if (evt_if.evt_valid) n_pres++; end
    set_src(0, 1'b0);
    for (int c = 0; c < 60; c++) begin tick(); if (evt_if.evt_valid) n_pres++; end
    chk("deb_pulse_events", 32'(n_pres), 32'd1);
`else
    n_pres = 0;
    set_src(0, 1'b1);
    tick();
    if (evt_if.evt_valid) n_pres++;
    set_src(0, 1'b0);
    for (int c = 0; c < 20; c++) begin tick(); if (evt_if.evt_valid) n_pres++; end
    chk("nodeb_glitch_events", 32'(n_pres), 32'd1);
`endif
    evt_if.evt_ready = 1'b0;
    chk("final_pending", 32'(pending), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
